fp18_accumulator: RTL and testbench
===================================

# fp18_accumulator

- Streaming floating-point accumulator that sits directly downstream of the 18-bit FP multiplier in each systolic-array processing element.
- Sums groups of `LEN` consecutive products into one 18-bit FP result and presents it on a valid/ready output register.
- Clears itself for the next group automatically.
- Number format: same as the multiplier.
  - Bit 17: sign.
  - Bits 16:11: exponent, 6 bits, bias 31.
  - Bits 10:0: mantissa, with hidden leading 1.

## Interface
- `LEN`, default 4: products per output sum; legal range 1..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` holds a product.
- `in_ready` output 1: block can accept `in_data` this cycle.
- `in_data` input 18: product from the multiplier.
- `out_valid` output 1: `out_data` holds a completed group sum.
- `out_ready` input 1: consumer takes `out_data` this cycle.
- `out_data` output 18: group sum.
- `ovf` output 1: valid with `out_data`; 1 if any add in the group overflowed.

## Operation
**Handshakes**
- Accept = `in_valid && in_ready`.
- `in_ready` = `!rst && (!out_valid || out_ready)`, combinational.
- Output transfer = `out_valid && out_ready`.

**State**
- Accumulator `acc`, 18 bits.
- Group counter `cnt`, 0..LEN-1.
- Group overflow flag `govf`.
- Output register holding `out_data`, `ovf` and `out_valid`.

**Per accept**
- `sum = fpadd(acc, in_data)`.
- If `cnt == LEN-1`:
  - `out_data <= sum`, `ovf <= govf | add_ovf`, `out_valid <= 1`.
  - `acc <= 0`, `cnt <= 0`, `govf <= 0`.
- Otherwise:
  - `acc <= sum`, `cnt <= cnt+1`, `govf <= govf | add_ovf`.

**Output register**
- Transfer without a simultaneous final accept: `out_valid <= 0`.
- Transfer with a simultaneous final accept: the new result loads and `out_valid` stays 1.

**fpadd rules**
- Any operand with exponent 0 is zero; the mantissa is ignored.
- Align:
  - Significands are 12 bits, `{1,mant}`.
  - The smaller-magnitude operand is right-shifted by the exponent difference.
  - Shifted-out bits are discarded, i.e. truncate toward zero.
  - Difference > 12: the smaller operand contributes 0.
- Same signs: add magnitudes. Different signs: subtract the smaller from the larger.
- Result sign is the sign of the larger-magnitude operand.
- Normalize:
  - Carry out: shift right 1 (drop the LSB) and increment the exponent.
  - Otherwise shift left to the leading one and decrement the exponent accordingly.
- Exact zero result: +0, `18'h00000`.
- Underflow, result exponent < 1: flush to +0, no flag.
- Overflow, result exponent > 62: sets `add_ovf`. The result value is defined under Configuration.
- Exponent 63 input: treated as an ordinary exponent, no special inf/NaN semantics.

**Reset**
- A partial group in progress is discarded.
- A pending output is dropped.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `ovf=0`.
  - `acc=0`, `cnt=0`, `govf=0`.
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after.
- One product accepted per cycle, full throughput, while the output is drained every cycle it is valid.
- Latency: `out_valid` rises the cycle after the LEN-th accept.
- `out_data`/`ovf` are held stable while `out_valid && !out_ready`. Meanwhile `in_ready=0`, so no input is lost.
- `in_valid` with `in_ready=0`: nothing changes; the upstream holds its data.
- `LEN=1`: every accept produces a result equal to `fpadd(0, in_data)`, i.e. `in_data` normalized or flushed.

## Configuration
- Macro `FPACC_SAT_EN`, a single compile-time switch.
- Defined:
  - Overflowed adds return the signed max finite value: `exp=62`, `mant=11'h7FF`. Positive max is `18'h1F7FF`.
  - The result's sign is kept.
- Undefined:
  - Overflowed adds return signed infinity: `exp=63`, `mant=0`. Positive is `18'h1F800`.
  - The result's sign is kept.
- `ovf` behaves identically in both builds.

## Test plan
- `LEN=4`: four accepts of `18'h0F800` (1.0) back-to-back with `out_ready=1` → `out_data=18'h10800` (4.0), `ovf=0` one cycle after the 4th accept.
- `LEN=4`: inputs 1.0, -1.0 (`18'h2F800`), 1.0, -1.0 → `out_data=18'h00000`. Then inputs 2.0 (`18'h10000`) and 1.0, followed by zeros → `18'h10400` (3.0).
- `LEN=2`: `18'h1F7FF` twice → `ovf=1`; `out_data=18'h1F7FF` with `FPACC_SAT_EN` defined, `18'h1F800` without. The next group of 1.0, 1.0 → `18'h10000`, `ovf=0`.
- `LEN=4`: hold `out_ready=0` after a result with `in_valid=1` → `in_ready=0` and `out_data` stable for 5 cycles. Raising `out_ready` transfers the result, and input resumes the same cycle.
- `LEN=4`: assert `rst` after 2 accepts → `out_valid=0`. The next 4 accepts of 1.0 give 4.0, not 6.0.
- `LEN=2`: 1.0 + `18'h01800` (exponent 3, diff 28) → `18'h0F800`, the small operand dropped. `18'h00123` (zero exponent) + 1.0 → `18'h0F800`.

Source files
------------

// File: rtl/fp18_accumulator.sv
// fp18_accumulator: sums groups of LEN fp18 products onto a valid/ready output register.
// FPACC_SAT_EN: overflowed adds saturate to max finite instead of returning infinity.
module fp18_accumulator #(
  parameter int LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic        ovf
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
`ifdef FPACC_SAT_EN
  localparam logic [16:0] OVF_MAG = {6'd62, 11'h7FF};
`else
  localparam logic [16:0] OVF_MAG = {6'd63, 11'h000};
`endif
  logic [17:0] acc, sum, big, sml;
  logic [CW-1:0] cnt;
  logic govf, add_ovf, accept, last, a_big, uf;
  logic [16:0] ka, kb;
  logic [11:0] mb, ms, msh;
  logic [5:0] diff;
  logic [12:0] raw;
  logic [3:0] lz;
  logic [10:0] norm;
  logic [7:0] e;
  always_comb begin
    ka = (acc[16:11] == 6'd0) ? 17'd0 : acc[16:0];
    kb = (in_data[16:11] == 6'd0) ? 17'd0 : in_data[16:0];
    a_big = ka >= kb;
    big = a_big ? acc : in_data;
    sml = a_big ? in_data : acc;
    mb = (big[16:11] == 6'd0) ? 12'd0 : {1'b1, big[10:0]};
    ms = (sml[16:11] == 6'd0) ? 12'd0 : {1'b1, sml[10:0]};
    diff = big[16:11] - sml[16:11];
    msh = (diff > 6'd12) ? 12'd0 : ms >> diff;
    raw = (big[17] == sml[17]) ? {1'b0, mb} + {1'b0, msh} : {1'b0, mb} - {1'b0, msh};
    lz = 4'd0;
    for (int i = 0; i < 12; i++) if (raw[i]) lz = 4'(11 - i);
    norm = raw[12] ? raw[11:1] : 11'(raw[11:0] << lz);
    // e is two's complement here so underflow below 1 shows up in e[7]
    e = raw[12] ? {2'b0, big[16:11]} + 8'd1 : {2'b0, big[16:11]} - {4'b0, lz};
    uf = (raw == 13'd0) || e[7] || (e == 8'd0);
    add_ovf = !uf && (e > 8'd62);
    sum = uf ? 18'd0 : add_ovf ? {big[17], OVF_MAG} : {big[17], e[5:0], norm};
  end
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      govf <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      ovf <= 1'b0;
    end else begin
      if (accept) begin
        acc <= last ? 18'd0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
        govf <= last ? 1'b0 : govf | add_ovf;
      end
      if (accept && last) begin
        out_data <= sum;
        ovf <= govf | add_ovf;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp18_accumulator.sv
// tb_fp18_accumulator: directed and randomized checks of fp18_accumulator against an integer-arithmetic model.
module tb_fp18_accumulator;
  localparam int LEN = 4;
`ifdef FPACC_SAT_EN
  localparam logic [17:0] OVF_POS = 18'h1F7FF;
`else
  localparam logic [17:0] OVF_POS = 18'h1F800;
`endif
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0, ovf;
  logic [17:0] in_data = 0, out_data;
  int total = 0, bad = 0;
  logic [17:0] m_acc, m_data;
  int m_cnt;
  logic m_govf, m_valid, m_ovf;

  fp18_accumulator #(.LEN(LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] ref_add(input logic [17:0] a, input logic [17:0] b);
    int ea, eb, ma, mb, e_big, e_sml, m_big, m_sml, c, r, e;
    logic s_big, s_sml, ab;
    ea = a[16:11];
    eb = b[16:11];
    ma = (ea == 0) ? 0 : 2048 + a[10:0];
    mb = (eb == 0) ? 0 : 2048 + b[10:0];
    ab = (ea > eb) || (ea == eb && ma >= mb);
    e_big = ab ? ea : eb;
    e_sml = ab ? eb : ea;
    m_big = ab ? ma : mb;
    m_sml = ab ? mb : ma;
    s_big = ab ? a[17] : b[17];
    s_sml = ab ? b[17] : a[17];
    c = (e_big - e_sml > 12) ? 0 : m_sml / (1 << (e_big - e_sml));
    r = (s_big == s_sml) ? m_big + c : m_big - c;
    if (r == 0) return 19'd0;
    e = e_big;
    while (r >= 4096) begin r = r / 2; e++; end
    while (r < 2048) begin r = r * 2; e--; end
    if (e < 1) return 19'd0;
    if (e > 62) return {1'b1, s_big, OVF_POS[16:0]};
    return {1'b0, s_big, 6'(e), 11'(r)};
  endfunction

  function automatic logic [17:0] rnd_fp();
    int k;
    logic [5:0] ex;
    k = $urandom_range(0, 7);
    ex = (k == 0) ? 6'd0 : (k == 1) ? 6'($urandom_range(58, 63)) : 6'($urandom_range(25, 37));
    return {1'($urandom_range(0, 1)), ex, 11'($urandom_range(0, 2047))};
  endfunction

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_govf = 0; m_valid = 0; m_data = 0; m_ovf = 0;
  endtask

  task automatic tick(input logic v, input logic [17:0] d, input logic r);
    logic rdy, xfer, fin;
    logic [18:0] s;
    in_valid = v; in_data = d; out_ready = r;
    rdy = !rst && (!m_valid || r);
    xfer = m_valid && r;
    fin = 0;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      if (v && rdy) begin
        s = ref_add(m_acc, d);
        if (m_cnt == LEN - 1) begin
          m_data = s[17:0]; m_ovf = m_govf | s[18]; m_valid = 1; fin = 1;
          m_acc = 0; m_cnt = 0; m_govf = 0;
        end else begin
          m_acc = s[17:0]; m_cnt++; m_govf = m_govf | s[18];
        end
      end
      if (xfer && !fin) m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic group4(input logic [17:0] a, b, c, d);
    tick(1, a, 1); tick(1, b, 1); tick(1, c, 1); tick(1, d, 1);
  endtask

  task automatic test_reset();
    rst = 1;
    tick(0, 0, 0);
    tick(1, 18'h0F800, 1);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if ({out_valid, ovf, out_data} !== 20'd0) begin bad++; $display("FAIL reset_outputs: got v=%b o=%b d=%h want all 0", out_valid, ovf, out_data); end
    rst = 0;
    tick(0, 0, 1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
  endtask

  task automatic test_sum4();
    tick(1, 18'h0F800, 1); tick(1, 18'h0F800, 1); tick(1, 18'h0F800, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid: got %b want 0", out_valid); end
    tick(1, 18'h0F800, 1);
    total++; if ({out_valid, ovf, out_data} !== {2'b10, 18'h10800}) begin bad++; $display("FAIL sum_four: got v=%b o=%b d=%h want v=1 o=0 d=10800", out_valid, ovf, out_data); end
    tick(0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain: got %b want 0", out_valid); end
  endtask

  task automatic test_cancel();
    group4(18'h0F800, 18'h2F800, 18'h0F800, 18'h2F800);
    total++; if ({out_valid, out_data} !== {1'b1, 18'h00000}) begin bad++; $display("FAIL cancel: got v=%b d=%h want v=1 d=00000", out_valid, out_data); end
    group4(18'h10000, 18'h0F800, 18'h0, 18'h0);
    total++; if ({out_valid, ovf, out_data} !== {2'b10, 18'h10400}) begin bad++; $display("FAIL three: got v=%b o=%b d=%h want 10400", out_valid, ovf, out_data); end
  endtask

  task automatic test_overflow();
    group4(18'h1F7FF, 18'h1F7FF, 18'h0, 18'h0);
    total++; if ({out_valid, ovf, out_data} !== {2'b11, OVF_POS}) begin bad++; $display("FAIL overflow: got v=%b o=%b d=%h want o=1 d=%h", out_valid, ovf, out_data, OVF_POS); end
    group4(18'h0F800, 18'h0F800, 18'h0, 18'h0);
    total++; if ({out_valid, ovf, out_data} !== {2'b10, 18'h10000}) begin bad++; $display("FAIL ovf_cleared: got o=%b d=%h want o=0 d=10000", ovf, out_data); end
  endtask

  task automatic test_stall();
    group4(18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 18'h10000; out_ready = 0;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: cycle %0d got %b want 0", i, in_ready); end
      tick(1, 18'h10000, 0);
      total++; if ({out_valid, out_data} !== {1'b1, 18'h10800}) begin bad++; $display("FAIL stall_hold: cycle %0d got v=%b d=%h want v=1 d=10800", i, out_valid, out_data); end
    end
    in_valid = 1; in_data = 18'h0F800; out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL resume_ready: got %b want 1", in_ready); end
    tick(1, 18'h0F800, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL resume_drain: got %b want 0", out_valid); end
    tick(1, 18'h0F800, 1); tick(1, 18'h0F800, 1); tick(1, 18'h0F800, 1);
    total++; if ({out_valid, out_data} !== {1'b1, 18'h10800}) begin bad++; $display("FAIL resume_sum: got v=%b d=%h want 10800", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    tick(1, 18'h0F800, 1); tick(1, 18'h0F800, 1);
    rst = 1;
    tick(0, 0, 1);
    rst = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    group4(18'h0F800, 18'h0F800, 18'h0F800, 18'h0F800);
    total++; if ({out_valid, out_data} !== {1'b1, 18'h10800}) begin bad++; $display("FAIL mid_reset_sum: got v=%b d=%h want 10800", out_valid, out_data); end
  endtask

  task automatic test_align();
    group4(18'h0F800, 18'h01800, 18'h0, 18'h0);
    total++; if (out_data !== 18'h0F800) begin bad++; $display("FAIL far_align: got %h want 0F800", out_data); end
    group4(18'h00123, 18'h0F800, 18'h0, 18'h0);
    total++; if (out_data !== 18'h0F800) begin bad++; $display("FAIL zero_exp: got %h want 0F800", out_data); end
  endtask

  task automatic test_random();
    logic v, r;
    logic [17:0] d;
    for (int i = 0; i < 800; i++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 3) != 0;
      d = rnd_fp();
      in_valid = v; in_data = d; out_ready = r;
      #1;
      total++; if (in_ready !== (!m_valid || r)) begin bad++; $display("FAIL rnd_ready: step %0d got %b want %b", i, in_ready, !m_valid || r); end
      tick(v, d, r);
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid: step %0d got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        total++; if ({ovf, out_data} !== {m_ovf, m_data}) begin bad++; $display("FAIL rnd_data: step %0d got o=%b d=%h want o=%b d=%h", i, ovf, out_data, m_ovf, m_data); end
      end
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_sum4();
    test_cancel();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_align();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
